fa_serial_add_ctrl: RTL and testbench
=====================================

// Module: fa_serial_add_ctrl
// PURPOSE
//  Sequencer that performs WIDTH-bit additions on a single 4-bit ripple adder
//  built from FA_verilog cells, one nibble per clock, LSB nibble first.
//  Registers the inter-nibble carry and shifts sum nibbles into a result register.
//  Sits between a valid/ready producer and consumer wherever wide adds must reuse the small adder.
// PARAMETERS
//  WIDTH  16  operand/result width in bits
//             - must be a multiple of 4 and >= 4; any other value is an elaboration error
//             - NNIB = WIDTH/4
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands offered
//  in_ready   out  1      controller can accept operands
//  op_a       in   WIDTH  operand A
//  op_b       in   WIDTH  operand B
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  sum        out  WIDTH  result, lower WIDTH bits
//  cout       out  1      carry out of MSB
//  ovf        out  1      signed overflow: carry into MSB ^ carry out of MSB
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset values (async, while rst_n=0):
//   - state=INIT; in_ready=0, out_valid=0, busy=0
//   - sum=0, cout=0, ovf=0; nibble index=0; carry reg=0
//  FSM:
//   - INIT -> IDLE on first clk edge after rst_n release
//   - IDLE: in_ready=1. On in_valid&&in_ready: latch op_a, op_b; carry=0; idx=0 -> RUN
//   - RUN: in_ready=0, busy=1. Each edge, nibble idx:
//       {c,s} = A[idx] + B[idx] + carry; s shifted into sum register; carry<=c; idx++
//     After nibble NNIB-1 -> DONE. cout=final c; ovf=a3^b3^s3^c of top nibble
//   - DONE: out_valid=1; sum/cout/ovf held stable until out_ready=1; then -> IDLE on that edge
//  Latency:
//   - accept at edge k -> out_valid high after edge k+NNIB
//   - earliest next accept at edge k+NNIB+2 (when out_ready=1 in DONE)
//  Ordering rules:
//   - in_valid ignored outside IDLE; no same-cycle accept while DONE
//   - op_a/op_b may change after accept without affecting the result
//  Visibility: sum/cout/ovf outputs update only on entry to DONE;
//   partial values never visible while out_valid=0 (outputs hold previous result)
//  Boundary:
//   - WIDTH=4 gives a 1-cycle RUN
//   - carry out of the top nibble is never fed back
//   - rst_n low in any state aborts the operation; all outputs return to reset values immediately
// CONFIGURATION
//  FA_SEQ_SUB_EN defined:
//   - adds input op_sub (1 bit), sampled at accept
//   - op_sub=1: B nibbles inverted, initial carry=1 (A-B); cout=1 means no borrow
//   - ovf uses the inverted B MSB
//  FA_SEQ_SUB_EN undefined: op_sub port absent; always A+B with initial carry=0
// TESTING (WIDTH=16)
//  0x1234+0x4321 -> sum=0x5555, cout=0, ovf=0; out_valid exactly 4 cycles after accept edge
//  0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0; 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1
//  out_ready=0 for 5 cycles in DONE, in_valid=1 throughout -> sum/out_valid stable, in_ready=0, no new accept
//  rst_n pulsed low during RUN at idx=2 -> outputs 0 immediately; next op 0x00FF+0x0001 -> 0x0100
//  Back-to-back ops with in_valid, out_ready tied 1 -> one result every 6 cycles, all correct
//  FA_SEQ_SUB_EN: 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0; 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1

Source files
------------

// File: rtl/fa_serial_add_ctrl.sv
// Serial WIDTH-bit adder sequencer: one 4-bit full-adder ripple per clock, LSB nibble first.
// Define FA_SEQ_SUB_EN to add the op_sub input (A-B via inverted B and carry-in of 1).
module fa_serial_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef FA_SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NNIB = WIDTH / 4;
    localparam int unsigned IdxW = (NNIB > 1) ? $clog2(NNIB) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("fa_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {StInit, StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic [3:0]        nib_s;
    logic [4:0]        rc;
    logic [WIDTH+3:0]  acc_shift;

    // Four full-adder cells rippling over the low nibble of the shifting operand registers.
    always_comb begin
        rc[0] = carry_q;
        nib_s = '0;
        for (int i = 0; i < 4; i++) begin
            nib_s[i]  = a_q[i] ^ b_q[i] ^ rc[i];
            rc[i + 1] = (a_q[i] & b_q[i]) | (rc[i] & (a_q[i] ^ b_q[i]));
        end
        acc_shift = {nib_s, acc_q};
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        unique case (state_q)
            StInit: begin
                state_d    = StIdle;
                in_ready_d = 1'b1;
            end
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    a_d        = op_a;
`ifdef FA_SEQ_SUB_EN
                    b_d        = op_b ^ {WIDTH{op_sub}};
                    carry_d    = op_sub;
`else
                    b_d        = op_b;
                    carry_d    = 1'b0;
`endif
                    idx_d      = '0;
                    state_d    = StRun;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            StRun: begin
                acc_d   = acc_shift[WIDTH+3:4];
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = rc[4];
                idx_d   = idx_q + IdxW'(1);
                if (idx_q == IdxW'(NNIB - 1)) begin
                    // Top nibble: publish the full result; its carry is never fed back.
                    state_d     = StDone;
                    sum_d       = acc_shift[WIDTH+3:4];
                    cout_d      = rc[4];
                    ovf_d       = rc[3] ^ rc[4];
                    out_valid_d = 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StInit;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fa_serial_add_ctrl.sv
// Scoreboard bench for fa_serial_add_ctrl (WIDTH=16, default add-only build).
module tb_fa_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    fa_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc;
        bit          gap;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   last_rise = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: latency/gap on each out_valid rise, result compare on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("latency", 32'(cyc - exp_q[0].acc), 32'd4);
                    if (exp_q[0].gap) chk("result gap", 32'(cyc - last_rise), 32'd6);
                end
                last_rise = cyc;
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.c));
                chk("ovf", 32'(ovf), 32'(e.o));
            end
        end
        prev_ov = out_valid;
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s,
                        input logic c, input logic o, input bit gap, input bit keep);
        int n = 0;
        @(posedge clk); #1;
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("in_ready wait", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back('{s: s, c: c, o: o, acc: cyc + 1, gap: gap});
        @(posedge clk); #1;
        op_a = 16'hDEAD;
        op_b = 16'hBEEF;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #2;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst sum", 32'(sum), 32'd0);
        chk("rst cout/ovf", 32'({cout, ovf}), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle in_ready", 32'(in_ready), 32'd1);
        chk("idle busy", 32'(busy), 32'd0);

        send(16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("run busy", 32'(busy), 32'd1);
        chk("run in_ready", 32'(in_ready), 32'd0);
        drain();
        send(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        send(16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();

        // Consumer stalls in DONE while a producer keeps offering operands.
        out_ready = 1'b0;
        send(16'h00AA, 16'h0055, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b1;
        op_a     = 16'h1111;
        op_b     = 16'h2222;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall out_valid", 32'(out_valid), 32'd1);
            chk("stall in_ready", 32'(in_ready), 32'd0);
            chk("stall sum", 32'(sum), 32'h00FF);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Abort mid-RUN with reset; previous result must vanish immediately.
        send(16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        chk("abort sum", 32'(sum), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort in_ready", 32'(in_ready), 32'd0);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        #1 rst_n = 1'b1;
        send(16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Back-to-back with in_valid held and out_ready tied high.
        send(16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1);
        send(16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
        send(16'h0F0F, 16'hF0F1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        send(16'hABCD, 16'h1111, 16'hBCDE, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
